// File: rtl/quiz_round_ctrl_if.sv
// Buzzer/host bus between the button front end and the round controller.
// Handshake: there is no valid/ready pair on this bus. Inputs are plain
// levels sampled on every rising clock edge, and only their 0->1 transitions
// act. Outputs are registered levels that are always valid.
interface quiz_round_if;
  logic       host_start;
  logic       host_clear;
  logic [2:0] con;
  logic [2:0] winner;
  logic [2:0] foul;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       beep;
  logic [1:0] state;

  // Stimulus/host side
  modport master (
    output host_start, host_clear, con,
    input  winner, foul, sec_tens, sec_ones, beep, state
  );

  // Controller side
  modport slave (
    input  host_start, host_clear, con,
    output winner, foul, sec_tens, sec_ones, beep, state
  );
endinterface

// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer and three-way buzzer arbiter with rotating priority,
// false-start lockout, BCD seconds countdown and beeper pulse.
module quiz_round_ctrl #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GRAB_SECS   = 10,
  parameter int ANSWER_SECS = 20,
  parameter int BEEP_CYCLES = 25_000_000
) (
  input  logic         clock,
  input  logic         reset,
  quiz_round_if.slave  bus
);

  localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
  localparam logic [3:0] GRAB_TENS   = 4'(GRAB_SECS / 10);
  localparam logic [3:0] GRAB_ONES   = 4'(GRAB_SECS % 10);
  localparam logic [3:0] ANSWER_TENS = 4'(ANSWER_SECS / 10);
  localparam logic [3:0] ANSWER_ONES = 4'(ANSWER_SECS % 10);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_ANSWER = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  state_t              r_state;
  logic [2:0]          r_winner;
  logic [2:0]          r_foul;
  logic [3:0]          r_tens;
  logic [3:0]          r_ones;
  logic [1:0]          r_ptr;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [BEEP_W-1:0]   r_beep_cnt;

  // Two-stage input capture: stage 1 samples the pins, stage 2 is the
  // previous sample, so rises act one edge after they are first seen.
  logic                r_start_q1, r_start_q2;
  logic                r_clear_q1, r_clear_q2;
  logic [2:0]          r_con_q1, r_con_q2;

  logic                w_start_rise;
  logic                w_clear_rise;
  logic [2:0]          w_con_rise;
  logic [2:0]          w_eligible;
  logic                w_tick;
  logic                w_zero;

  state_t              w_next_state;
  logic                w_load_grab;
  logic                w_load_answer;
  logic                w_dec;
  logic                w_fire;
  logic                w_clear;
  logic [2:0]          w_foul_set;
  logic [2:0]          w_grant;

  logic [2:0]          w_arb;
  logic [1:0]          w_arb_idx;
  logic [1:0]          w_ptr_next;

  assign w_start_rise = r_start_q1 & ~r_start_q2;
  assign w_clear_rise = r_clear_q1 & ~r_clear_q2;
  assign w_con_rise   = r_con_q1 & ~r_con_q2;
  assign w_eligible   = w_con_rise & ~r_foul;
  assign w_tick       = (r_tick_cnt == TICK_LAST);
  assign w_zero       = (r_tens == 4'd0) && (r_ones == 4'd0);

  // Register raw inputs and their previous samples for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_start_q1 <= 1'b0;
      r_start_q2 <= 1'b0;
      r_clear_q1 <= 1'b0;
      r_clear_q2 <= 1'b0;
      r_con_q1   <= 3'b000;
      r_con_q2   <= 3'b000;
    end else begin
      r_start_q1 <= bus.host_start;
      r_start_q2 <= r_start_q1;
      r_clear_q1 <= bus.host_clear;
      r_clear_q2 <= r_clear_q1;
      r_con_q1   <= bus.con;
      r_con_q2   <= r_con_q1;
    end
  end

  // Rotating-priority pick: first eligible index in order p, p+1, p+2
  always_comb begin
    w_arb     = 3'b000;
    w_arb_idx = 2'd0;
    case (r_ptr)
      2'd1: begin
        if      (w_eligible[1]) begin w_arb = 3'b010; w_arb_idx = 2'd1; end
        else if (w_eligible[2]) begin w_arb = 3'b100; w_arb_idx = 2'd2; end
        else if (w_eligible[0]) begin w_arb = 3'b001; w_arb_idx = 2'd0; end
      end
      2'd2: begin
        if      (w_eligible[2]) begin w_arb = 3'b100; w_arb_idx = 2'd2; end
        else if (w_eligible[0]) begin w_arb = 3'b001; w_arb_idx = 2'd0; end
        else if (w_eligible[1]) begin w_arb = 3'b010; w_arb_idx = 2'd1; end
      end
      default: begin
        if      (w_eligible[0]) begin w_arb = 3'b001; w_arb_idx = 2'd0; end
        else if (w_eligible[1]) begin w_arb = 3'b010; w_arb_idx = 2'd1; end
        else if (w_eligible[2]) begin w_arb = 3'b100; w_arb_idx = 2'd2; end
      end
    endcase
    w_ptr_next = (w_arb_idx == 2'd2) ? 2'd0 : (w_arb_idx + 2'd1);
  end

  // Round FSM: next state plus one-cycle action strobes; clear overrides all
  always_comb begin
    w_next_state  = r_state;
    w_load_grab   = 1'b0;
    w_load_answer = 1'b0;
    w_dec         = 1'b0;
    w_fire        = 1'b0;
    w_clear       = 1'b0;
    w_foul_set    = 3'b000;
    w_grant       = 3'b000;
    if (w_clear_rise) begin
      w_next_state = ST_IDLE;
      w_clear      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_foul_set = w_con_rise;
          if (w_start_rise) begin
            w_next_state = ST_ARMED;
            w_load_grab  = 1'b1;
          end
        end
        ST_ARMED: begin
          // A press beats an expiry tick landing on the same cycle
          if (|w_eligible) begin
            w_grant       = w_arb;
            w_next_state  = ST_ANSWER;
            w_load_answer = 1'b1;
            w_fire        = 1'b1;
          end else if (w_tick) begin
            if (w_zero) begin
              w_next_state = ST_DONE;
              w_fire       = 1'b1;
            end else begin
              w_dec = 1'b1;
            end
          end
        end
        ST_ANSWER: begin
          if (w_tick) begin
            if (w_zero) begin
              w_next_state = ST_DONE;
              w_fire       = 1'b1;
            end else begin
              w_dec = 1'b1;
            end
          end
        end
        default: begin
          w_next_state = r_state;
        end
      endcase
    end
  end

  // State, winner, lockouts and arbitration pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_winner <= 3'b000;
      r_foul   <= 3'b000;
      r_ptr    <= 2'd0;
    end else begin
      r_state <= w_next_state;
      if (w_clear || w_load_grab) begin
        r_winner <= 3'b000;
      end else if (|w_grant) begin
        r_winner <= w_grant;
      end
      if (w_clear) begin
        r_foul <= 3'b000;
      end else begin
        r_foul <= r_foul | w_foul_set;
      end
      if (|w_grant) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  // BCD seconds countdown; guarded by w_zero so it never wraps below 00
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (w_clear) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (w_load_grab) begin
      r_tens <= GRAB_TENS;
      r_ones <= GRAB_ONES;
    end else if (w_load_answer) begin
      r_tens <= ANSWER_TENS;
      r_ones <= ANSWER_ONES;
    end else if (w_dec) begin
      if (r_ones == 4'd0) begin
        r_ones <= 4'd9;
        r_tens <= r_tens - 4'd1;
      end else begin
        r_ones <= r_ones - 4'd1;
      end
    end
  end

  // One-second divider, restarted on every countdown load
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (w_load_grab || w_load_answer || w_clear) begin
      r_tick_cnt <= '0;
    end else if (r_state == ST_ARMED || r_state == ST_ANSWER) begin
      r_tick_cnt <= w_tick ? '0 : (r_tick_cnt + 1'b1);
    end else begin
      r_tick_cnt <= '0;
    end
  end

  // Beeper pulse stretcher; a new firing reloads, clear leaves it running
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_beep_cnt <= '0;
    end else if (w_fire) begin
      r_beep_cnt <= BEEP_W'(BEEP_CYCLES);
    end else if (r_beep_cnt != '0) begin
      r_beep_cnt <= r_beep_cnt - 1'b1;
    end
  end

  assign bus.state    = r_state;
  assign bus.winner   = r_winner;
  assign bus.foul     = r_foul;
  assign bus.sec_tens = r_tens;
  assign bus.sec_ones = r_ones;
  assign bus.beep     = (r_beep_cnt != '0);

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl with CLK_HZ=4, GRAB_SECS=3,
// ANSWER_SECS=5, BEEP_CYCLES=2. Inputs change 1ns after a rising edge and
// outputs are sampled at the same point, away from the active edge.
module tb_quiz_round_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  quiz_round_if bus ();

  quiz_round_ctrl #(
    .CLK_HZ      (4),
    .GRAB_SECS   (3),
    .ANSWER_SECS (5),
    .BEEP_CYCLES (2)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // host_start pulse; returns on the edge that enters ARMED
  task automatic do_start();
    bus.host_start = 1'b1;
    step(1);
    bus.host_start = 1'b0;
    step(1);
  endtask

  // host_clear pulse; returns on the edge that enters IDLE
  task automatic do_clear();
    bus.host_clear = 1'b1;
    step(1);
    bus.host_clear = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.host_start = 1'b0;
    bus.host_clear = 1'b0;
    bus.con = 3'b000;
    step(3);
    n_checks++; if (bus.state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", bus.state); end
    n_checks++; if (bus.winner !== 3'b000) begin n_fail++; $display("FAIL reset_winner: got %b expected 000", bus.winner); end
    n_checks++; if (bus.foul !== 3'b000) begin n_fail++; $display("FAIL reset_foul: got %b expected 000", bus.foul); end
    n_checks++; if (bus.sec_tens !== 4'd0 || bus.sec_ones !== 4'd0) begin n_fail++; $display("FAIL reset_digits: got %0d%0d expected 00", bus.sec_tens, bus.sec_ones); end
    n_checks++; if (bus.beep !== 1'b0) begin n_fail++; $display("FAIL reset_beep: got %b expected 0", bus.beep); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_foul();
    bus.con = 3'b010;
    step(1);
    n_checks++; if (bus.foul !== 3'b000) begin n_fail++; $display("FAIL foul_latency: got %b expected 000", bus.foul); end
    step(1);
    n_checks++; if (bus.foul !== 3'b010) begin n_fail++; $display("FAIL foul_set: got %b expected 010", bus.foul); end
    n_checks++; if (bus.state !== 2'b00) begin n_fail++; $display("FAIL foul_state: got %b expected 00", bus.state); end
    bus.con = 3'b000;
    step(1);
    do_start();
    n_checks++; if (bus.state !== 2'b01) begin n_fail++; $display("FAIL armed_state: got %b expected 01", bus.state); end
    n_checks++; if (bus.sec_tens !== 4'd0 || bus.sec_ones !== 4'd3) begin n_fail++; $display("FAIL armed_digits: got %0d%0d expected 03", bus.sec_tens, bus.sec_ones); end
    bus.con = 3'b010;
    step(2);
    n_checks++; if (bus.winner !== 3'b000 || bus.state !== 2'b01) begin n_fail++; $display("FAIL fouled_press: got winner %b state %b expected 000 01", bus.winner, bus.state); end
    bus.con = 3'b000;
    do_clear();
    n_checks++; if (bus.state !== 2'b00 || bus.foul !== 3'b000) begin n_fail++; $display("FAIL foul_clear: got state %b foul %b expected 00 000", bus.state, bus.foul); end
  endtask

  task automatic test_single_grant();
    do_start();
    bus.con = 3'b100;
    step(1);
    n_checks++; if (bus.state !== 2'b01 || bus.winner !== 3'b000) begin n_fail++; $display("FAIL grant_early: got state %b winner %b expected 01 000", bus.state, bus.winner); end
    step(1);
    bus.con = 3'b000;
    n_checks++; if (bus.winner !== 3'b100) begin n_fail++; $display("FAIL grant_winner: got %b expected 100", bus.winner); end
    n_checks++; if (bus.state !== 2'b10) begin n_fail++; $display("FAIL grant_state: got %b expected 10", bus.state); end
    n_checks++; if (bus.sec_tens !== 4'd0 || bus.sec_ones !== 4'd5) begin n_fail++; $display("FAIL grant_digits: got %0d%0d expected 05", bus.sec_tens, bus.sec_ones); end
    n_checks++; if (bus.beep !== 1'b1) begin n_fail++; $display("FAIL grant_beep1: got %b expected 1", bus.beep); end
    step(1);
    n_checks++; if (bus.beep !== 1'b1) begin n_fail++; $display("FAIL grant_beep2: got %b expected 1", bus.beep); end
    step(1);
    n_checks++; if (bus.beep !== 1'b0) begin n_fail++; $display("FAIL grant_beep_off: got %b expected 0", bus.beep); end
    n_checks++; if (bus.sec_ones !== 4'd5) begin n_fail++; $display("FAIL answer_hold5: got %0d expected 5", bus.sec_ones); end
    step(2);
    n_checks++; if (bus.sec_ones !== 4'd4) begin n_fail++; $display("FAIL answer_step4: got %0d expected 4", bus.sec_ones); end
    for (int d = 3; d >= 0; d--) begin
      step(4);
      n_checks++; if (bus.sec_ones !== 4'(d) || bus.sec_tens !== 4'd0) begin n_fail++; $display("FAIL answer_step: got %0d%0d expected 0%0d", bus.sec_tens, bus.sec_ones, d); end
    end
    step(3);
    n_checks++; if (bus.state !== 2'b10) begin n_fail++; $display("FAIL answer_before_done: got %b expected 10", bus.state); end
    step(1);
    n_checks++; if (bus.state !== 2'b11 || bus.beep !== 1'b1 || bus.winner !== 3'b100) begin n_fail++; $display("FAIL answer_done: got state %b beep %b winner %b expected 11 1 100", bus.state, bus.beep, bus.winner); end
    step(1);
    n_checks++; if (bus.beep !== 1'b1) begin n_fail++; $display("FAIL done_beep2: got %b expected 1", bus.beep); end
    step(1);
    n_checks++; if (bus.beep !== 1'b0 || bus.state !== 2'b11) begin n_fail++; $display("FAIL done_hold: got beep %b state %b expected 0 11", bus.beep, bus.state); end
    do_clear();
  endtask

  task automatic test_rotating();
    logic [2:0] pats [0:4];
    logic [2:0] exps [0:4];
    pats[0] = 3'b111; exps[0] = 3'b001;  // p 0 -> 1
    pats[1] = 3'b111; exps[1] = 3'b010;  // p 1 -> 2
    pats[2] = 3'b111; exps[2] = 3'b100;  // p 2 -> 0
    pats[3] = 3'b001; exps[3] = 3'b001;  // p 0 -> 1
    pats[4] = 3'b101; exps[4] = 3'b100;  // p 1: order 1,2,0 -> 2; p -> 0
    for (int i = 0; i < 5; i++) begin
      do_start();
      bus.con = pats[i];
      step(2);
      bus.con = 3'b000;
      n_checks++; if (bus.winner !== exps[i]) begin n_fail++; $display("FAIL rotate_%0d: got %b expected %b", i, bus.winner, exps[i]); end
      do_clear();
    end
  endtask

  task automatic test_grab_timeout();
    do_start();
    n_checks++; if (bus.sec_ones !== 4'd3) begin n_fail++; $display("FAIL grab_load: got %0d expected 3", bus.sec_ones); end
    for (int d = 2; d >= 0; d--) begin
      step(4);
      n_checks++; if (bus.sec_ones !== 4'(d) || bus.state !== 2'b01) begin n_fail++; $display("FAIL grab_step: got %0d state %b expected %0d 01", bus.sec_ones, bus.state, d); end
    end
    step(3);
    n_checks++; if (bus.state !== 2'b01) begin n_fail++; $display("FAIL grab_before_done: got %b expected 01", bus.state); end
    step(1);
    n_checks++; if (bus.state !== 2'b11 || bus.winner !== 3'b000 || bus.beep !== 1'b1) begin n_fail++; $display("FAIL grab_done: got state %b winner %b beep %b expected 11 000 1", bus.state, bus.winner, bus.beep); end
    step(1);
    n_checks++; if (bus.beep !== 1'b1) begin n_fail++; $display("FAIL grab_beep2: got %b expected 1", bus.beep); end
    step(1);
    n_checks++; if (bus.beep !== 1'b0) begin n_fail++; $display("FAIL grab_beep_off: got %b expected 0", bus.beep); end
    do_clear();
  endtask

  task automatic test_simultaneous();
    // Press rise lands on the expiry-tick cycle (p=0 -> grant 1, p -> 2)
    do_start();
    step(14);
    bus.con = 3'b010;
    step(1);
    n_checks++; if (bus.state !== 2'b01) begin n_fail++; $display("FAIL expiry_pre: got %b expected 01", bus.state); end
    step(1);
    bus.con = 3'b000;
    n_checks++; if (bus.state !== 2'b10 || bus.winner !== 3'b010) begin n_fail++; $display("FAIL expiry_press: got state %b winner %b expected 10 010", bus.state, bus.winner); end
    n_checks++; if (bus.sec_ones !== 4'd5) begin n_fail++; $display("FAIL expiry_digits: got %0d expected 5", bus.sec_ones); end
    do_clear();
    // Clear and start rising together
    bus.host_clear = 1'b1;
    bus.host_start = 1'b1;
    step(1);
    bus.host_clear = 1'b0;
    bus.host_start = 1'b0;
    step(1);
    n_checks++; if (bus.state !== 2'b00) begin n_fail++; $display("FAIL clear_start_1: got %b expected 00", bus.state); end
    step(2);
    n_checks++; if (bus.state !== 2'b00) begin n_fail++; $display("FAIL clear_start_2: got %b expected 00", bus.state); end
    // Press rising with a clear is dropped, then held across start (p=2)
    bus.host_clear = 1'b1;
    bus.con = 3'b001;
    step(1);
    bus.host_clear = 1'b0;
    step(1);
    n_checks++; if (bus.foul !== 3'b000) begin n_fail++; $display("FAIL held_no_foul: got %b expected 000", bus.foul); end
    do_start();
    step(2);
    n_checks++; if (bus.state !== 2'b01 || bus.winner !== 3'b000) begin n_fail++; $display("FAIL held_no_grant: got state %b winner %b expected 01 000", bus.state, bus.winner); end
    bus.con = 3'b000;
    step(1);
    bus.con = 3'b001;
    step(2);
    bus.con = 3'b000;
    n_checks++; if (bus.state !== 2'b10 || bus.winner !== 3'b001) begin n_fail++; $display("FAIL held_repress: got state %b winner %b expected 10 001", bus.state, bus.winner); end
    do_clear();
  endtask

  task automatic test_clear_mid_answer();
    // p=1 here. Lock out contestant 2, then grant contestant 1 (p -> 2).
    bus.con = 3'b100;
    step(2);
    bus.con = 3'b000;
    n_checks++; if (bus.foul !== 3'b100) begin n_fail++; $display("FAIL mid_foul_set: got %b expected 100", bus.foul); end
    do_start();
    bus.con = 3'b010;
    step(2);
    bus.con = 3'b000;
    n_checks++; if (bus.winner !== 3'b010 || bus.state !== 2'b10) begin n_fail++; $display("FAIL mid_grant: got winner %b state %b expected 010 10", bus.winner, bus.state); end
    step(3);
    bus.host_clear = 1'b1;
    step(1);
    bus.host_clear = 1'b0;
    n_checks++; if (bus.state !== 2'b10) begin n_fail++; $display("FAIL mid_clear_latency: got %b expected 10", bus.state); end
    step(1);
    n_checks++; if (bus.state !== 2'b00 || bus.winner !== 3'b000 || bus.foul !== 3'b000) begin n_fail++; $display("FAIL mid_clear: got state %b winner %b foul %b expected 00 000 000", bus.state, bus.winner, bus.foul); end
    n_checks++; if (bus.sec_tens !== 4'd0 || bus.sec_ones !== 4'd0) begin n_fail++; $display("FAIL mid_clear_digits: got %0d%0d expected 00", bus.sec_tens, bus.sec_ones); end
    do_start();
    bus.con = 3'b111;
    step(2);
    bus.con = 3'b000;
    n_checks++; if (bus.winner !== 3'b100) begin n_fail++; $display("FAIL mid_next_round: got %b expected 100", bus.winner); end
    do_clear();
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_foul();
    test_single_grant();
    test_rotating();
    test_grab_timeout();
    test_simultaneous();
    test_clear_mid_answer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
